output_deproc: RTL

// - Inverse of the input processing stage on the SDR receive path.
// - Takes unsigned offset-binary codes (code = 4*(x+8), x in [-8,7]) and recovers signed 4-bit samples.
// - Steps: remove mid-scale offset, optionally average 2^AVG_LOG2 samples, round, saturate.
// - Sits between the processing core and the signed sample consumer. Valid/ready on both sides.

---
 rtl/output_deproc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/output_deproc.sv
// Offset-binary to signed sample recovery: offset removal, optional 2^AVG_LOG2 averaging,
// round-half-up, saturation. Define OUT_DEPROC_SAT_CNT_EN to add the sat_cnt event counter port.
module output_deproc #(
    parameter int IN_W     = 7,
    parameter int OUT_W    = 4,
    parameter int OFFSET   = 32,
    parameter int SHIFT    = 2,
    parameter int AVG_LOG2 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
`ifdef OUT_DEPROC_SAT_CNT_EN
    ,
    output logic [7:0]       sat_cnt
`endif
);

    localparam int ACC_W   = IN_W + 1 + AVG_LOG2;
    localparam int K       = SHIFT + AVG_LOG2;
    localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_W - 1));

    localparam logic signed [IN_W:0]  OFF_D = (IN_W + 1)'(OFFSET);
    localparam logic signed [ACC_W:0] RND   = (ACC_W + 1)'((K > 0) ? (2 ** (K - 1)) : 0);
    localparam logic signed [ACC_W:0] MAX_W = (ACC_W + 1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] MIN_W = (ACC_W + 1)'(OUT_MIN);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                  state;
    logic signed [IN_W:0]    d;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   r;
    logic                    accept;
    logic                    last;
    logic                    clip_hi;
    logic                    clip_lo;
    logic [OUT_W-1:0]        res;

    assign out_valid = (state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    // A sample offered during clr is dropped even though in_ready may be high.
    assign accept    = in_valid && in_ready && !clr;

    assign d   = $signed({1'b0, in_data}) - OFF_D;
    assign sum = {acc[ACC_W-1], acc} + {{(AVG_LOG2 + 1){d[IN_W]}}, d};
    assign rnd = sum + RND;
    assign r   = rnd >>> K;

    assign clip_hi = (r > MAX_W);
    assign clip_lo = (r < MIN_W);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res = r[OUT_W-1:0];
        if (clip_hi) begin
            res = MAX_W[OUT_W-1:0];
        end else if (clip_lo) begin
            res = MIN_W[OUT_W-1:0];
        end
    end

    generate
        if (AVG_LOG2 > 0) begin : g_cnt
            logic [AVG_LOG2-1:0] grp_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grp_cnt <= '0;
                end else if (clr) begin
                    grp_cnt <= '0;
                end else if (accept) begin
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end

            assign last = &grp_cnt;
        end else begin : g_no_cnt
            assign last = 1'b1;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ACCUM;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clr) begin
            state <= S_ACCUM;
            acc   <= '0;
        end else if (accept) begin
            if (last) begin
                acc      <= '0;
                out_data <= res;
                out_sat  <= clip_hi || clip_lo;
                state    <= S_FULL;
            end else begin
                acc <= sum[ACC_W-1:0];
                if (out_valid && out_ready) begin
                    state <= S_ACCUM;
                end
            end
        end else if (out_valid && out_ready) begin
            state <= S_ACCUM;
        end
    end

`ifdef OUT_DEPROC_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 8'd0;
        end else if (out_valid && out_ready && out_sat && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end
`endif

endmodule
